// File: rtl/intr_ctrl_if.sv
// Signal bundle between interrupt sources / control unit (master) and intr_ctrl (slave).
interface intr_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_wr;
  logic [NUM_IRQ-1:0] mask_din;
  logic               INT_ACK;
  logic               eoi;
  logic               INTR;
  logic [3:0]         irq_id;
  logic [31:0]        vec_addr;
  logic [NUM_IRQ-1:0] pending;
  logic [3:0]         depth;
  logic               eoi_err;

  modport master (
    output irq_in, mask_wr, mask_din, INT_ACK, eoi,
    input  INTR, irq_id, vec_addr, pending, depth, eoi_err
  );

  modport slave (
    input  irq_in, mask_wr, mask_din, INT_ACK, eoi,
    output INTR, irq_id, vec_addr, pending, depth, eoi_err
  );
endinterface

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: edge-latched pending bits, mask, fixed priority, ISR stack.
// Define INTR_CTRL_NESTING_EN to allow preemption up to NEST_DEPTH nested ISRs.
module intr_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_03C0
) (
  input logic        sys_clk,
  input logic        reset,
  intr_ctrl_if.slave bus
);

`ifdef INTR_CTRL_NESTING_EN
  localparam int DepthLim = NEST_DEPTH;
  localparam bit NestEn   = 1'b1;
`else
  localparam int DepthLim = 1;
  localparam bit NestEn   = 1'b0;
`endif
  localparam int StkW = (DepthLim > 1) ? $clog2(DepthLim) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irqPrev_q, pending_q, pending_d, mask_q;
  logic [NUM_IRQ-1:0] rise, eligible, ackClr;
  logic [3:0]         irqId_q, irqId_d, depth_q, depth_d;
  logic [31:0]        vecAddr_q, vecAddr_d;
  logic [3:0]         stack_q [DepthLim];
  logic [3:0]         winnerId, topId, topIdx, wrIdx;
  logic               hasWinner, grant, push, pop, eoiErr_q;

  assign rise     = bus.irq_in & ~irqPrev_q;
  assign eligible = pending_q & ~mask_q;
  assign push     = (state_q == REQ) && bus.INT_ACK;
  assign pop      = bus.eoi && (depth_q != 4'd0);
  assign ackClr   = push ? (NUM_IRQ'(1) << irqId_q) : '0;
  assign pending_d = (pending_q & ~ackClr) | rise;
  assign depth_d   = depth_q + {3'b000, push} - {3'b000, pop};

  // Pop happens before push, so a simultaneous eoi overwrites the current top.
  assign wrIdx  = depth_q - {3'b000, pop};
  assign topIdx = (depth_q == 4'd0) ? 4'd0 : depth_q - 4'd1;
  assign topId  = stack_q[StkW'(topIdx)];

  always_comb begin
    winnerId = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winnerId = 4'(i);
    end
  end

  assign hasWinner = |eligible;
  assign grant = hasWinner &&
                 ((depth_q == 4'd0) ||
                  (NestEn && (depth_q < 4'(DepthLim)) && (winnerId < topId)));

  always_comb begin
    state_d   = state_q;
    irqId_d   = irqId_q;
    vecAddr_d = vecAddr_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = REQ;
          irqId_d   = winnerId;
          vecAddr_d = VEC_BASE + {26'd0, winnerId, 2'b00};
        end
      end
      REQ: begin
        if (bus.INT_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      irqId_q   <= '0;
      vecAddr_q <= VEC_BASE;
      irqPrev_q <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      depth_q   <= '0;
      eoiErr_q  <= 1'b0;
      for (int i = 0; i < DepthLim; i++) stack_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      irqId_q   <= irqId_d;
      vecAddr_q <= vecAddr_d;
      irqPrev_q <= bus.irq_in;
      pending_q <= pending_d;
      depth_q   <= depth_d;
      if (bus.mask_wr) mask_q <= bus.mask_din;
      if (bus.eoi && (depth_q == 4'd0)) eoiErr_q <= 1'b1;
      if (push) stack_q[StkW'(wrIdx)] <= irqId_q;
    end
  end

  assign bus.INTR     = (state_q == REQ);
  assign bus.irq_id   = irqId_q;
  assign bus.vec_addr = vecAddr_q;
  assign bus.pending  = pending_q;
  assign bus.depth    = depth_q;
  assign bus.eoi_err  = eoiErr_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl; expectations follow INTR_CTRL_NESTING_EN.
module tb_intr_ctrl;
  localparam int NumIrq = 8;

  logic sys_clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;

  intr_ctrl_if #(.NUM_IRQ(NumIrq)) bus ();

  intr_ctrl #(
    .NUM_IRQ   (NumIrq),
    .NEST_DEPTH(2),
    .VEC_BASE  (32'h0000_03C0)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCore(input string tag, input logic intr, input logic [3:0] id,
                           input logic [7:0] pend, input logic [3:0] dep);
    checkOutput({tag, ".INTR"}, 32'(bus.INTR), 32'(intr));
    if (intr) begin
      checkOutput({tag, ".irq_id"}, 32'(bus.irq_id), 32'(id));
      checkOutput({tag, ".vec_addr"}, bus.vec_addr, 32'h0000_03C0 + 32'(id) * 32'd4);
    end
    checkOutput({tag, ".pending"}, 32'(bus.pending), 32'(pend));
    checkOutput({tag, ".depth"}, 32'(bus.depth), 32'(dep));
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NumIrq-1:0] irq, input logic ack, input logic eoiP);
    bus.irq_in  = irq;
    bus.INT_ACK = ack;
    bus.eoi     = eoiP;
    stepCycle();
    bus.INT_ACK = 1'b0;
    bus.eoi     = 1'b0;
  endtask

  task automatic writeMask(input logic [NumIrq-1:0] din);
    bus.mask_wr  = 1'b1;
    bus.mask_din = din;
    stepCycle();
    bus.mask_wr  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.irq_in   = '0;
    bus.mask_wr  = 1'b0;
    bus.mask_din = '0;
    bus.INT_ACK  = 1'b0;
    bus.eoi      = 1'b0;
    stepCycle();
    checkCore("reset", 1'b0, 4'd0, 8'h00, 4'd0);
    checkOutput("reset.irq_id", 32'(bus.irq_id), 32'd0);
    checkOutput("reset.vec_addr", bus.vec_addr, 32'h0000_03C0);
    checkOutput("reset.eoi_err", 32'(bus.eoi_err), 32'd0);
    reset = 1'b0;

    // single request on channel 3
    applyStimulus(8'h08, 1'b0, 1'b0); checkCore("t1.pend", 1'b0, 4'd0, 8'h08, 4'd0);
    applyStimulus(8'h08, 1'b0, 1'b0); checkCore("t1.req",  1'b1, 4'd3, 8'h08, 4'd0);
    applyStimulus(8'h08, 1'b1, 1'b0); checkCore("t1.ack",  1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h08, 1'b0, 1'b1); checkCore("t1.eoi",  1'b0, 4'd0, 8'h00, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // channels 5 and 2 together: 2 first, 5 only after its eoi
    applyStimulus(8'h24, 1'b0, 1'b0); checkCore("t2.pend",  1'b0, 4'd0, 8'h24, 4'd0);
    applyStimulus(8'h24, 1'b0, 1'b0); checkCore("t2.req2",  1'b1, 4'd2, 8'h24, 4'd0);
    applyStimulus(8'h24, 1'b1, 1'b0); checkCore("t2.ack2",  1'b0, 4'd0, 8'h20, 4'd1);
    applyStimulus(8'h24, 1'b0, 1'b0); checkCore("t2.wait",  1'b0, 4'd0, 8'h20, 4'd1);
    applyStimulus(8'h24, 1'b0, 1'b1); checkCore("t2.eoi2",  1'b0, 4'd0, 8'h20, 4'd0);
    applyStimulus(8'h24, 1'b0, 1'b0); checkCore("t2.req5",  1'b1, 4'd5, 8'h20, 4'd0);
    applyStimulus(8'h24, 1'b1, 1'b0); checkCore("t2.ack5",  1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h24, 1'b0, 1'b1); checkCore("t2.eoi5",  1'b0, 4'd0, 8'h00, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // channel 1 arrives while ISR 4 is active
    applyStimulus(8'h10, 1'b0, 1'b0);
    applyStimulus(8'h10, 1'b0, 1'b0); checkCore("t3.req4",  1'b1, 4'd4, 8'h10, 4'd0);
    applyStimulus(8'h10, 1'b1, 1'b0); checkCore("t3.ack4",  1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h12, 1'b0, 1'b0); checkCore("t3.pend1", 1'b0, 4'd0, 8'h02, 4'd1);
    applyStimulus(8'h12, 1'b0, 1'b0);
`ifdef INTR_CTRL_NESTING_EN
    checkCore("t3.preempt", 1'b1, 4'd1, 8'h02, 4'd1);
    applyStimulus(8'h12, 1'b1, 1'b0); checkCore("t3.ack1", 1'b0, 4'd0, 8'h00, 4'd2);
    applyStimulus(8'h12, 1'b0, 1'b1); checkCore("t3.eoi1", 1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h12, 1'b0, 1'b1); checkCore("t3.eoi4", 1'b0, 4'd0, 8'h00, 4'd0);
`else
    checkCore("t3.blocked", 1'b0, 4'd0, 8'h02, 4'd1);
    applyStimulus(8'h12, 1'b0, 1'b1); checkCore("t3.eoi4", 1'b0, 4'd0, 8'h02, 4'd0);
    applyStimulus(8'h12, 1'b0, 1'b0); checkCore("t3.req1", 1'b1, 4'd1, 8'h02, 4'd0);
    applyStimulus(8'h12, 1'b1, 1'b0); checkCore("t3.ack1", 1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h12, 1'b0, 1'b1); checkCore("t3.eoi1", 1'b0, 4'd0, 8'h00, 4'd0);
`endif
    applyStimulus(8'h00, 1'b0, 1'b0);

    // masked channel 0 stays pending until unmasked
    writeMask(8'h01);
    applyStimulus(8'h01, 1'b0, 1'b0); checkCore("t4.pend",   1'b0, 4'd0, 8'h01, 4'd0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0); checkCore("t4.masked", 1'b0, 4'd0, 8'h01, 4'd0);
    writeMask(8'h00);                  checkCore("t4.unmask",  1'b0, 4'd0, 8'h01, 4'd0);
    applyStimulus(8'h01, 1'b0, 1'b0); checkCore("t4.req0",   1'b1, 4'd0, 8'h01, 4'd0);
    applyStimulus(8'h01, 1'b1, 1'b0); checkCore("t4.ack0",   1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h01, 1'b0, 1'b1); checkCore("t4.eoi0",   1'b0, 4'd0, 8'h00, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // eoi with nothing active
    checkOutput("t5.errBefore", 32'(bus.eoi_err), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("t5.err", 32'(bus.eoi_err), 32'd1);
    checkCore("t5.noChange", 1'b0, 4'd0, 8'h00, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("t5.sticky", 32'(bus.eoi_err), 32'd1);

    // full stack blocks grants, then eoi and ack in the same cycle
    applyStimulus(8'h20, 1'b0, 1'b0);
    applyStimulus(8'h20, 1'b0, 1'b0); checkCore("t6.req5", 1'b1, 4'd5, 8'h20, 4'd0);
    applyStimulus(8'h20, 1'b1, 1'b0); checkCore("t6.ack5", 1'b0, 4'd0, 8'h00, 4'd1);
`ifdef INTR_CTRL_NESTING_EN
    applyStimulus(8'h28, 1'b0, 1'b0);
    applyStimulus(8'h28, 1'b0, 1'b0); checkCore("t6.req3",   1'b1, 4'd3, 8'h08, 4'd1);
    applyStimulus(8'h28, 1'b1, 1'b0); checkCore("t6.ack3",   1'b0, 4'd0, 8'h00, 4'd2);
    applyStimulus(8'h2A, 1'b0, 1'b0);
    applyStimulus(8'h2A, 1'b0, 1'b0);
    applyStimulus(8'h2A, 1'b0, 1'b0); checkCore("t6.full",   1'b0, 4'd0, 8'h02, 4'd2);
    applyStimulus(8'h2A, 1'b0, 1'b1); checkCore("t6.eoi3",   1'b0, 4'd0, 8'h02, 4'd1);
    applyStimulus(8'h2A, 1'b0, 1'b0); checkCore("t6.req1",   1'b1, 4'd1, 8'h02, 4'd1);
    applyStimulus(8'h2A, 1'b1, 1'b1); checkCore("t6.ackEoi", 1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h2A, 1'b0, 1'b1); checkCore("t6.eoi1",   1'b0, 4'd0, 8'h00, 4'd0);
`else
    applyStimulus(8'h28, 1'b0, 1'b0);
    applyStimulus(8'h28, 1'b0, 1'b0); checkCore("t6.blocked", 1'b0, 4'd0, 8'h08, 4'd1);
    applyStimulus(8'h2A, 1'b0, 1'b0);
    applyStimulus(8'h2A, 1'b0, 1'b0); checkCore("t6.full",    1'b0, 4'd0, 8'h0A, 4'd1);
    applyStimulus(8'h2A, 1'b0, 1'b1); checkCore("t6.eoi5",    1'b0, 4'd0, 8'h0A, 4'd0);
    applyStimulus(8'h2A, 1'b0, 1'b0); checkCore("t6.req1",    1'b1, 4'd1, 8'h0A, 4'd0);
    applyStimulus(8'h2A, 1'b1, 1'b1); checkCore("t6.ackEoi",  1'b0, 4'd0, 8'h08, 4'd1);
    applyStimulus(8'h2A, 1'b0, 1'b1); checkCore("t6.eoi1",    1'b0, 4'd0, 8'h08, 4'd0);
    applyStimulus(8'h2A, 1'b0, 1'b0); checkCore("t6.req3",    1'b1, 4'd3, 8'h08, 4'd0);
    applyStimulus(8'h2A, 1'b1, 1'b0); checkCore("t6.ack3",    1'b0, 4'd0, 8'h00, 4'd1);
    applyStimulus(8'h2A, 1'b0, 1'b1); checkCore("t6.eoi3",    1'b0, 4'd0, 8'h00, 4'd0);
`endif
    applyStimulus(8'h00, 1'b0, 1'b0);

    // asynchronous reset while requesting with pending = 0x0A
    applyStimulus(8'h0A, 1'b0, 1'b0); checkCore("t7.pend", 1'b0, 4'd0, 8'h0A, 4'd0);
    applyStimulus(8'h0A, 1'b0, 1'b0); checkCore("t7.req",  1'b1, 4'd1, 8'h0A, 4'd0);
    #2;
    reset = 1'b1;
    #1;
    checkCore("t7.async", 1'b0, 4'd0, 8'h00, 4'd0);
    checkOutput("t7.async.irq_id", 32'(bus.irq_id), 32'd0);
    checkOutput("t7.async.vec_addr", bus.vec_addr, 32'h0000_03C0);
    checkOutput("t7.async.eoi_err", 32'(bus.eoi_err), 32'd0);
    stepCycle();
    checkCore("t7.held", 1'b0, 4'd0, 8'h00, 4'd0);
    reset = 1'b0;
    stepCycle();
    checkCore("t7.resample", 1'b0, 4'd0, 8'h0A, 4'd0);
    stepCycle();
    checkCore("t7.reqAgain", 1'b1, 4'd1, 8'h0A, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_IRQ, 8, request channel count (2..16); NEST_DEPTH, 4, max nested active ISRs (1..8); VEC_BASE, 32'h0000_03C0, vector table base byte address.
REQ-002 Ports SHALL be: sys_clk  in  1  clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-003 irq_in  in  NUM_IRQ  interrupt request lines, edge-detected on rising edge.
REQ-004 mask_wr  in  1  pulse: load mask_din into mask register.
REQ-005 mask_din  in  NUM_IRQ  mask value; bit=1 disables that channel.
REQ-006 INT_ACK  in  1  one-cycle pulse from control unit accepting the current request.
REQ-007 eoi  in  1  one-cycle pulse: end of the innermost active ISR.
REQ-008 INTR  out  1  request to control unit.
REQ-009 irq_id  out  4  channel being requested (held while INTR=1).
REQ-010 vec_addr  out  32  VEC_BASE + 4*irq_id.
REQ-011 pending  out  NUM_IRQ  latched pending bits.
REQ-012 depth  out  4  number of active (acknowledged, not ended) ISRs.
REQ-013 eoi_err  out  1  sticky: eoi received with depth=0.

Function
REQ-014 irq_in SHALL be registered each cycle; pending[i] sets when irq_in[i]=1 and its registered copy=0.
REQ-015 Eligible set SHALL be pending & ~mask; winner SHALL be lowest eligible index (index 0 highest priority).
REQ-016 FSM SHALL have states IDLE and REQ; INTR=1 exactly in REQ.
REQ-017 IDLE->REQ when a winner exists and grant condition holds; irq_id and vec_addr latch the winner on that edge; INTR rises one cycle after pending is set.
REQ-018 Grant condition: depth=0, or (depth<NEST_DEPTH and winner index < top-of-stack id).
REQ-019 In REQ, irq_id SHALL NOT change, even if a higher-priority channel pends or the winner is masked.
REQ-020 REQ->IDLE on INT_ACK: push irq_id on active stack, depth+1, clear pending[irq_id]; INTR low next cycle.
REQ-021 New rising edge on the acknowledged channel in the same cycle as INT_ACK SHALL leave pending set (set wins).
REQ-022 INT_ACK in IDLE SHALL be ignored.
REQ-023 eoi with depth>0 SHALL pop the stack, depth-1; eoi with depth=0 SHALL set eoi_err and change nothing else.
REQ-024 eoi and INT_ACK in the same cycle SHALL pop first, then push; depth unchanged, top = new irq_id.
REQ-025 Stack full (depth=NEST_DEPTH) SHALL block new grants; pending bits keep accumulating.
REQ-026 mask_wr SHALL take effect on the next arbitration cycle; it never clears pending.
REQ-027 A grant re-evaluates only in IDLE; no combinational path from irq_in to INTR.

Reset
REQ-028 Reset SHALL force IDLE, INTR=0, irq_id=0, vec_addr=VEC_BASE, pending=0, mask=0 (all enabled), depth=0, stack cleared, eoi_err=0, irq_in history=0.
REQ-029 Reset asserted mid-REQ or with ISRs active SHALL discard all state immediately; first edge after release is sampled normally.

Configuration
REQ-030 Macro INTR_CTRL_NESTING_EN defined: nesting/preemption per REQ-018 with NEST_DEPTH stack.
REQ-031 Macro undefined: effective depth limit 1; grant only when depth=0; no preemption; stack reduces to one register; all other behaviour identical.

Verification
REQ-032 Single IRQ: irq_in[3] 0->1 -> pending[3]=1, INTR=1 next cycle, irq_id=3, vec_addr=0x3CC; INT_ACK -> INTR=0, pending[3]=0, depth=1.
REQ-033 Priority: irq_in[5] and irq_in[2] rise together -> irq_id=2, vec_addr=0x3C8; after ACK, REQ for 5 only after eoi (5 > top 2).
REQ-034 Nesting (macro on): active id 4, irq_in[1] rises -> INTR, irq_id=1, ACK -> depth=2; eoi -> depth=1; macro off -> no INTR until eoi.
REQ-035 Mask: mask_din=0x01, irq_in[0] rises -> no INTR, pending[0]=1; mask_din=0x00 -> INTR, irq_id=0.
REQ-036 Boundaries: eoi at depth=0 -> eoi_err=1; NEST_DEPTH=2 with ids 5,3 active, irq 1 rises -> no INTR until eoi; eoi+ACK same cycle -> depth unchanged.
REQ-037 Reset during REQ with pending=0x0A -> INTR=0, pending=0, depth=0 asynchronously.
